macn_pipe: RTL

Parametrised N-lane pipelined multiply-accumulate unit, successor to the fixed three-lane MAC in the PE datapath. Each accepted token multiplies N operand pairs, reduces the products through a registered adder tree, then adds either the running accumulator or an external partial sum. Unlike the previous generation, tokens carry their own valid bit, the pipeline supports back-pressure, and the output stage rounds and saturates. It sits between the PE operand buffers and the partial-sum write-back path.

---
 rtl/macn_pkg.sv | 54 +++++
 rtl/macn_if.sv | 32 +++
 rtl/macn_tree_level.sv | 47 ++++
 rtl/macn_pipe.sv | 114 +++++++++++
 4 files changed

// File: rtl/macn_pkg.sv
// Shared types and helpers for the N-lane pipelined MAC: tree sizing plus output rounding/saturation.
package macn_pkg;

  // Output arithmetic runs at this width so rounding never wraps; accumulators must stay below it.
  localparam int WIDE_WIDTH = 64;
  localparam int DEFAULT_ACC_WIDTH = 32;
  localparam int DEFAULT_OUT_WIDTH = 16;

  typedef logic signed [WIDE_WIDTH-1:0] wide_t;

  typedef struct packed {
    logic  sat;
    wide_t value;
  } sat_result_t;

  function automatic int tree_depth(input int n);
    int d;
    d = 0;
    while ((1 << d) < n) d++;
    return d;
  endfunction

  function automatic int level_count(input int n, input int level);
    return (n + (1 << level) - 1) >> level;
  endfunction

  function automatic wide_t round_shift(input wide_t v, input int scale, input bit round_en);
    wide_t r;
    r = v;
    if (round_en && scale > 0) r = v + (wide_t'(1) <<< (scale - 1));
    return r >>> scale;
  endfunction

  function automatic sat_result_t saturate(input wide_t s, input int out_width, input bit sat_en);
    sat_result_t res;
    wide_t max_v;
    wide_t min_v;
    max_v = (wide_t'(1) <<< (out_width - 1)) - wide_t'(1);
    min_v = -(wide_t'(1) <<< (out_width - 1));
    res.sat = 1'b0;
    res.value = s;
    if (sat_en) begin
      if (s > max_v) begin
        res.sat = 1'b1;
        res.value = max_v;
      end else if (s < min_v) begin
        res.sat = 1'b1;
        res.value = min_v;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/macn_if.sv
// Token-in / result-out handshake bundle of the MAC pipeline.
interface macn_if #(
  parameter int N_LANES = 3,
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int OUTPUT_WIDTH = 16
);
  import macn_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic                          accumulate_internal;
  logic [ACCUMULATOR_WIDTH-1:0]  partial_sum_in;
  logic [N_LANES*A_WIDTH-1:0]    a;
  logic [N_LANES*B_WIDTH-1:0]    b;
  logic                          out_valid;
  logic                          out_ready;
  logic [OUTPUT_WIDTH-1:0]       out;
  logic                          sat_flag;

  modport master (
    output in_valid, accumulate_internal, partial_sum_in, a, b, out_ready,
    input  in_ready, out_valid, out, sat_flag
  );

  modport slave (
    input  in_valid, accumulate_internal, partial_sum_in, a, b, out_ready,
    output in_ready, out_valid, out, sat_flag
  );

endinterface

// File: rtl/macn_tree_level.sv
// One registered pairwise-reduction level of the product adder tree; sidebands ride along.
module macn_tree_level
  import macn_pkg::*;
#(
  parameter int IN_COUNT = 2,
  parameter int WIDTH = DEFAULT_ACC_WIDTH,
  localparam int OUT_COUNT = (IN_COUNT + 1) / 2
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic                       in_acc_int,
  input  logic [WIDTH-1:0]           in_psum,
  input  logic [IN_COUNT*WIDTH-1:0]  in_terms,
  output logic                       out_valid,
  output logic                       out_acc_int,
  output logic [WIDTH-1:0]           out_psum,
  output logic [OUT_COUNT*WIDTH-1:0] out_terms
);

  logic [OUT_COUNT*WIDTH-1:0] terms_d;

  // An odd trailing term has no partner and is simply re-registered.
  for (genvar i = 0; i < OUT_COUNT; i++) begin : g_pair
    if (2*i + 1 < IN_COUNT) begin : g_add
      assign terms_d[i*WIDTH +: WIDTH] = in_terms[2*i*WIDTH +: WIDTH] + in_terms[(2*i+1)*WIDTH +: WIDTH];
    end else begin : g_pass
      assign terms_d[i*WIDTH +: WIDTH] = in_terms[2*i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid   <= 1'b0;
      out_acc_int <= 1'b0;
      out_psum    <= '0;
      out_terms   <= '0;
    end else if (en) begin
      out_valid   <= in_valid;
      out_acc_int <= in_acc_int;
      out_psum    <= in_psum;
      out_terms   <= terms_d;
    end
  end

endmodule

// File: rtl/macn_pipe.sv
// N-lane pipelined multiply-accumulate: product stage, registered adder tree, accumulate stage,
// combinational round/shift/saturate output. ACCUMULATOR_WIDTH must stay below 64.
module macn_pipe
  import macn_pkg::*;
#(
  parameter int N_LANES = 3,
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int ACCUMULATOR_WIDTH = DEFAULT_ACC_WIDTH,
  parameter int OUTPUT_WIDTH = DEFAULT_OUT_WIDTH,
  parameter int OUTPUT_SCALE = 0,
  parameter int ROUND = 0,
  parameter int SATURATE = 1
) (
  input  logic   clk,
  input  logic   arst_n_in,
  macn_if.slave  bus
);

  localparam int TREE_DEPTH = tree_depth(N_LANES);
  localparam int ACC_W = ACCUMULATOR_WIDTH;

  logic                              en;
  logic                              take;
  logic                              out_valid_q;
  logic signed [ACC_W-1:0]           acc_q;
  logic [N_LANES*ACC_W-1:0]          prod_d;
  logic [TREE_DEPTH:0][N_LANES*ACC_W-1:0] lvl_terms;
  logic [TREE_DEPTH:0]               lvl_valid;
  logic [TREE_DEPTH:0]               lvl_acc_int;
  logic [TREE_DEPTH:0][ACC_W-1:0]    lvl_psum;
  logic signed [ACC_W-1:0]           tree_sum;
  logic signed [ACC_W-1:0]           addend;
  logic signed [ACC_W-1:0]           sum;

  // A single enable freezes every stage whenever a held result is not being taken.
  assign en = !out_valid_q || bus.out_ready;
  assign take = bus.in_valid && en;
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_q;

  for (genvar i = 0; i < N_LANES; i++) begin : g_mul
    logic signed [ACC_W-1:0] a_ext;
    logic signed [ACC_W-1:0] b_ext;
    assign a_ext = ACC_W'($signed(bus.a[i*A_WIDTH +: A_WIDTH]));
    assign b_ext = ACC_W'($signed(bus.b[i*B_WIDTH +: B_WIDTH]));
    assign prod_d[i*ACC_W +: ACC_W] = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      lvl_terms[0]   <= '0;
      lvl_valid[0]   <= 1'b0;
      lvl_acc_int[0] <= 1'b0;
      lvl_psum[0]    <= '0;
    end else if (en) begin
      lvl_terms[0]   <= prod_d;
      lvl_valid[0]   <= take;
      lvl_acc_int[0] <= bus.accumulate_internal;
      lvl_psum[0]    <= bus.partial_sum_in;
    end
  end

  for (genvar l = 0; l < TREE_DEPTH; l++) begin : g_level
    localparam int IN_COUNT = level_count(N_LANES, l);
    localparam int OUT_COUNT = level_count(N_LANES, l + 1);
    logic [OUT_COUNT*ACC_W-1:0] terms_q;

    macn_tree_level #(
      .IN_COUNT (IN_COUNT),
      .WIDTH    (ACC_W)
    ) u_level (
      .clk         (clk),
      .arst_n      (arst_n_in),
      .en          (en),
      .in_valid    (lvl_valid[l]),
      .in_acc_int  (lvl_acc_int[l]),
      .in_psum     (lvl_psum[l]),
      .in_terms    (lvl_terms[l][IN_COUNT*ACC_W-1:0]),
      .out_valid   (lvl_valid[l+1]),
      .out_acc_int (lvl_acc_int[l+1]),
      .out_psum    (lvl_psum[l+1]),
      .out_terms   (terms_q)
    );

    assign lvl_terms[l+1] = (N_LANES*ACC_W)'(terms_q);
  end

  assign tree_sum = lvl_terms[TREE_DEPTH][ACC_W-1:0];
  assign addend = lvl_acc_int[TREE_DEPTH] ? acc_q : lvl_psum[TREE_DEPTH];
  assign sum = tree_sum + addend;

  // Bubbles advance out_valid but leave the accumulator alone.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      out_valid_q <= 1'b0;
      acc_q       <= '0;
    end else if (en) begin
      out_valid_q <= lvl_valid[TREE_DEPTH];
      if (lvl_valid[TREE_DEPTH]) acc_q <= sum;
    end
  end

  wide_t       scaled;
  sat_result_t res;

  always_comb begin
    scaled = round_shift(wide_t'(acc_q), OUTPUT_SCALE, ROUND != 0);
    res = saturate(scaled, OUTPUT_WIDTH, SATURATE != 0);
    bus.out = res.value[OUTPUT_WIDTH-1:0];
    bus.sat_flag = res.sat;
  end

endmodule
